adc_spi_capture: RTL and testbench
==================================

ADC_SPI_CAPTURE -- requirements
Module: adc_spi_capture

Interface
REQ-001 SHALL have parameter W, default 25: output sample width, signed two's complement.
REQ-002 SHALL have parameter ADC_BITS, default 12: ADC code width, carried in the last ADC_BITS bits of a 16-bit frame.
REQ-003 SHALL have parameter SHIFT, default 10: left shift applied to the code to place it in the filter's fixed-point format; ADC_BITS+SHIFT+1 <= W is required.
REQ-004 SHALL have parameter CLK_DIV, default 4: ADC_SCLK half-period in CLK cycles, >= 1.
REQ-005 SHALL have parameter SAMPLE_PERIOD, default 2000: CLK cycles between conversion starts (50 kHz at 100 MHz).
REQ-006 CLK  input  1  system clock; all logic on the rising edge; one clock domain.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 Run  input  1  high = periodic conversions enabled.
REQ-009 ADC_SDATA  input  1  serial data from the ADC.
REQ-010 ADC_CS_n  output  1  ADC chip select, active low.
REQ-011 ADC_SCLK  output  1  serial clock to the ADC; idles high.
REQ-012 u  output  W  signed sample for the filter chain; held between strobes.
REQ-013 Enable  output  1  one-CLK strobe marking a new u; drives the filter chain's Enable.
REQ-014 Overrun  output  1  sticky flag: a conversion start was lost.

Function
REQ-015 The period counter SHALL count 0..SAMPLE_PERIOD-1 and wrap while Run=1; it SHALL be held at 0 while Run=0; a tick SHALL occur in the cycle the count equals SAMPLE_PERIOD-1.
REQ-016 The FSM SHALL have states IDLE, SETUP, SHIFT and DONE; it SHALL leave IDLE only on a tick.
REQ-017 In IDLE, a tick SHALL move the FSM to SETUP; ADC_CS_n SHALL go low on the next cycle.
REQ-018 SETUP SHALL last CLK_DIV cycles with ADC_SCLK high, then move to SHIFT.
REQ-019 SHIFT SHALL generate 16 ADC_SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high; ADC_SDATA SHALL be sampled MSB-first on each ADC_SCLK rising edge.
REQ-020 After the 16th rising edge the FSM SHALL enter DONE for exactly one cycle, then return to IDLE.
REQ-021 In DONE, ADC_CS_n SHALL be high, u SHALL be updated and Enable SHALL be high.
REQ-022 Enable SHALL rise exactly 1+33*CLK_DIV cycles after the tick cycle (133 cycles at default settings).
REQ-023 u SHALL equal the formatted code (REQ-030/REQ-031) shifted left by SHIFT and sign-extended to W; the low SHIFT bits SHALL be zero.
REQ-024 A tick arriving while the FSM is not in IDLE SHALL be ignored and SHALL set Overrun; Overrun SHALL clear only on Reset.
REQ-025 Run falling mid-frame SHALL let the current frame complete, including its Enable strobe; no new frame SHALL start.
REQ-026 Enable SHALL never be high in two consecutive cycles.

Reset
REQ-027 On Reset: FSM = IDLE, counter = 0, ADC_CS_n = 1, ADC_SCLK = 1, u = 0, Enable = 0, Overrun = 0, effective on the next CLK edge.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no Enable strobe; u SHALL reset to 0.
REQ-029 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-030 With ADC_OFFSET_BINARY_EN defined, the code SHALL be treated as offset binary: midscale (2^(ADC_BITS-1)) is subtracted, giving a signed value in -2048..2047 for 12 bits.
REQ-031 Without ADC_OFFSET_BINARY_EN, the code SHALL be zero-extended as unsigned, giving 0..4095 for 12 bits.

Verification
REQ-032 Defaults, macro on, ADC returns 0x800 -> u = 0 and Enable pulses once, 133 cycles after the tick.
REQ-033 Macro on, codes 0xFFF then 0x000 -> u = 2096128, then u = -2097152; Enable spacing = 2000 cycles.
REQ-034 Macro off, code 0xFFF -> u = 4193280.
REQ-035 SAMPLE_PERIOD = 100 -> Overrun = 1 at the second tick; Enable spacing = 200 cycles (every other tick).
REQ-036 Reset pulsed at cycle 60 of a frame -> ADC_CS_n = 1 and ADC_SCLK = 1 on the next edge, no Enable, u = 0.
REQ-037 Run dropped at cycle 50 of a frame -> that frame's Enable is still produced; no ADC_CS_n low afterwards.

Source files
------------

// File: rtl/adc_spi_capture_if.sv
// adc_spi_capture_if
//   Groups the ADC serial bus and the sample-output strobe/flags of
//   adc_spi_capture into one bundle.
//   Signals:
//     ADC_SDATA  serial data from the ADC
//     ADC_CS_n   ADC chip select, active low
//     ADC_SCLK   serial clock to the ADC, idles high
//     u          signed W-bit sample, held between strobes
//     Enable     one-cycle strobe marking a new u
//     Overrun    sticky flag, a conversion start was lost
//   Modports:
//     master  the capture block (drives the ADC bus and the sample outputs)
//     slave   the ADC / filter side
//   W must match the W of the adc_spi_capture instance it is bound to.
interface adc_spi_capture_if #(
    parameter int W = 25
);
    logic                ADC_SDATA;
    logic                ADC_CS_n;
    logic                ADC_SCLK;
    logic signed [W-1:0] u;
    logic                Enable;
    logic                Overrun;

    modport master (
        input  ADC_SDATA,
        output ADC_CS_n,
        output ADC_SCLK,
        output u,
        output Enable,
        output Overrun
    );

    modport slave (
        output ADC_SDATA,
        input  ADC_CS_n,
        input  ADC_SCLK,
        input  u,
        input  Enable,
        input  Overrun
    );
endinterface

// File: rtl/adc_spi_capture.sv
// adc_spi_capture
//   Periodically reads a 16-bit frame from a serial ADC, formats the
//   ADC_BITS-bit code carried in the low bits of the frame into a signed
//   W-bit fixed-point sample (code << SHIFT) and strobes it to the filter
//   chain.
//   Ports:
//     CLK      system clock, rising edge
//     Reset    synchronous, active-high
//     Run      high = periodic conversions enabled
//     bus      adc_spi_capture_if.master: ADC_SDATA in; ADC_CS_n, ADC_SCLK,
//              u, Enable, Overrun out
//   Build option:
//     ADC_OFFSET_BINARY_EN  defined   -> code is offset binary (midscale = 0)
//                           undefined -> code is unsigned, zero-extended
//   Frame timing (tick in cycle T): CS_n low from T+1, SETUP CLK_DIV cycles
//   with SCLK high, 16 SCLK periods (low then high, CLK_DIV cycles each),
//   DONE with Enable high in cycle T+1+33*CLK_DIV.
module adc_spi_capture #(
    parameter int W             = 25,
    parameter int ADC_BITS      = 12,
    parameter int SHIFT         = 10,
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 2000
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Run,
    adc_spi_capture_if.master  bus
);

    localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [4:0]          edge_q, edge_d;
    logic [ADC_BITS-1:0] sreg_q, sreg_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                enable_q, enable_d;
    logic                overrun_q, overrun_d;
    logic signed [W-1:0] u_q, u_d;

    logic                tick;
    logic                div_last;
    logic signed [W-1:0] code_ext;

    assign tick     = Run && (cnt_q == CNT_LAST);
    assign div_last = (div_q == DIV_LAST);

    // Only the last ADC_BITS bits of the 16-bit frame survive in sreg_q.
`ifdef ADC_OFFSET_BINARY_EN
    // Inverting the MSB of an offset-binary code gives its two's-complement value.
    assign code_ext = {{(W-ADC_BITS+1){~sreg_q[ADC_BITS-1]}}, sreg_q[ADC_BITS-2:0]};
`else
    assign code_ext = {{(W-ADC_BITS){1'b0}}, sreg_q};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = (!Run || tick) ? '0 : cnt_q + CNT_W'(1);
        div_d     = div_q;
        edge_d    = edge_q;
        sreg_d    = sreg_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        enable_d  = 1'b0;
        overrun_d = overrun_q;
        u_d       = u_q;

        if (tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SETUP;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b1;
                    div_d   = '0;
                end
            end
            ST_SETUP: begin
                if (div_last) begin
                    state_d = ST_SHIFT;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    edge_d  = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                if (!div_last) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // Rising SCLK edge: capture the bit the ADC presented.
                        sclk_d = 1'b1;
                        sreg_d = {sreg_q[ADC_BITS-2:0], bus.ADC_SDATA};
                        edge_d = edge_q + 5'd1;
                    end else if (edge_q == 5'd16) begin
                        // End of the 16th high phase: frame complete.
                        state_d  = ST_DONE;
                        cs_n_d   = 1'b1;
                        enable_d = 1'b1;
                        u_d      = code_ext << SHIFT;
                    end else begin
                        sclk_d = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            edge_q    <= '0;
            sreg_q    <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            enable_q  <= 1'b0;
            overrun_q <= 1'b0;
            u_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            sreg_q    <= sreg_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            enable_q  <= enable_d;
            overrun_q <= overrun_d;
            u_q       <= u_d;
        end
    end

    assign bus.ADC_CS_n = cs_n_q;
    assign bus.ADC_SCLK = sclk_q;
    assign bus.u        = u_q;
    assign bus.Enable   = enable_q;
    assign bus.Overrun  = overrun_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// tb_adc_spi_capture
//   Two instances share clock, Reset and Run: instance 0 uses the default
//   2000-cycle sample period, instance 1 a 100-cycle period that is shorter
//   than a frame, so every other start is lost. Each instance has an ADC
//   model that serves a 16-bit word MSB-first and a frame-offset reference
//   model of the expected outputs, compared on every falling CLK edge.
module tb_adc_spi_capture;
    localparam int W   = 25;
    localparam int AB  = 12;
    localparam int SH  = 10;
    localparam int CD  = 4;
    localparam int FL  = 1 + 33 * CD;   // tick-to-Enable distance
    localparam int SP0 = 2000;
    localparam int SP1 = 100;

`ifdef ADC_OFFSET_BINARY_EN
    localparam longint U_800 = 0;
    localparam longint U_FFF = 2096128;
    localparam longint U_000 = -2097152;
`else
    localparam longint U_800 = 2097152;
    localparam longint U_FFF = 4193280;
    localparam longint U_000 = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic                cs_w   [2];
    logic                sclk_w [2];
    logic                en_w   [2];
    logic                ovr_w  [2];
    logic signed [W-1:0] u_w    [2];

    logic [15:0] dir_q0[$];
    int unsigned en_at [2][0:511];
    longint      en_u  [2][0:511];
    int unsigned en_n  [2] = '{default: 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint fmt(input int unsigned code);
`ifdef ADC_OFFSET_BINARY_EN
        return (longint'(code) - (longint'(1) << (AB - 1))) * (longint'(1) << SH);
`else
        return longint'(code) * (longint'(1) << SH);
`endif
    endfunction

    task automatic check(input string name, input int inst,
                         input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cycle %0d: got %0d expected %0d", name, inst, cyc, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int SP = (g == 0) ? SP0 : SP1;

        adc_spi_capture_if #(.W(W)) bus ();

        adc_spi_capture #(
            .W(W), .ADC_BITS(AB), .SHIFT(SH), .CLK_DIV(CD), .SAMPLE_PERIOD(SP)
        ) dut (
            .CLK(clk), .Reset(rst), .Run(run), .bus(bus)
        );

        assign cs_w[g]   = bus.ADC_CS_n;
        assign sclk_w[g] = bus.ADC_SCLK;
        assign en_w[g]   = bus.Enable;
        assign ovr_w[g]  = bus.Overrun;
        assign u_w[g]    = bus.u;

        // ADC: new word on CS_n fall, next bit after each SCLK fall.
        logic        sdata     = 1'b0;
        logic [15:0] word      = '0;
        logic        prev_cs   = 1'b1;
        logic        prev_sclk = 1'b1;
        int          nfall     = 0;
        assign bus.ADC_SDATA = sdata;

        always @(negedge clk) begin
            if (prev_cs === 1'b1 && cs_w[g] === 1'b0) begin
                if (g == 0 && dir_q0.size() != 0) word = dir_q0.pop_front();
                else word = 16'($urandom);
                nfall = 0;
                sdata = 1'($urandom);
            end else if (cs_w[g] === 1'b0 && prev_sclk === 1'b1 && sclk_w[g] === 1'b0) begin
                nfall++;
                if (nfall <= 16) sdata = word[16 - nfall];
            end
            prev_cs   = cs_w[g];
            prev_sclk = sclk_w[g];
        end

        // Reference: off = cycles since the accepted tick (1..FL while active).
        int     cnt = 0;
        int     off = 0;
        bit     active = 1'b0;
        bit     ovr = 1'b0;
        bit     chk = 1'b0;
        bit     tick_m;
        longint u_exp = 0;

        always @(posedge clk) begin
            if (rst) begin
                cnt = 0; off = 0; active = 1'b0; ovr = 1'b0; u_exp = 0; chk = 1'b1;
            end else begin
                tick_m = run && (cnt == SP - 1);
                if (tick_m && active) ovr = 1'b1;
                if (tick_m && !active) begin
                    active = 1'b1;
                    off    = 1;
                end else if (active) begin
                    off++;
                    if (off > FL) begin
                        active = 1'b0;
                        off    = 0;
                    end
                end
                if (active && off == FL) u_exp = fmt(int'(word[AB-1:0]));
                cnt = (!run || tick_m) ? 0 : cnt + 1;
            end
        end

        bit e_cs, e_sclk, e_en;
        always @(negedge clk) begin
            if (chk) begin
                e_cs   = !(active && off <= 33 * CD);
                e_sclk = 1'b1;
                if (active && off >= CD + 1 && off <= 33 * CD)
                    e_sclk = (((off - CD - 1) / CD) % 2) == 1;
                e_en   = active && (off == FL);
                check("cs_n",    g, cs_w[g],   e_cs);
                check("sclk",    g, sclk_w[g], e_sclk);
                check("enable",  g, en_w[g],   e_en);
                check("overrun", g, ovr_w[g],  ovr);
                check("u",       g, u_w[g],    u_exp);
                if (en_w[g] === 1'b1 && en_n[g] < 512) begin
                    en_at[g][en_n[g]] = cyc;
                    en_u[g][en_n[g]]  = longint'(u_w[g]);
                    en_n[g]++;
                end
            end
        end
    end

    initial begin
        int unsigned r, t0, t1, nb, cs_low, hold;

        rst = 1'b1; run = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_cs_n", i, cs_w[i], 1);
            check("rst_sclk", i, sclk_w[i], 1);
            check("rst_en",   i, en_w[i], 0);
            check("rst_ovr",  i, ovr_w[i], 0);
            check("rst_u",    i, u_w[i], 0);
        end

        // Directed codes for instance 0; instance 1 overruns every other tick.
        dir_q0.push_back({4'hA, 12'h800});
        dir_q0.push_back({4'h5, 12'hFFF});
        dir_q0.push_back({4'hF, 12'h000});
        rst = 1'b0; run = 1'b1;
        r = cyc;
        while (cyc < r + 3 * SP0 + 200) begin
            @(negedge clk);
            if (cyc == r + 199) check("ovr_before_2nd_tick", 1, ovr_w[1], 0);
            if (cyc == r + 200) check("ovr_after_2nd_tick",  1, ovr_w[1], 1);
        end
        check("en0_count",   0, en_n[0], 3);
        check("en0_latency", 0, en_at[0][0], r + SP0 - 1 + 133);
        check("u_800",       0, en_u[0][0], U_800);
        check("u_FFF",       0, en_u[0][1], U_FFF);
        check("u_000",       0, en_u[0][2], U_000);
        check("en0_spacing", 0, en_at[0][1] - en_at[0][0], 2000);
        check("en1_latency", 1, en_at[1][0], r + SP1 - 1 + 133);
        check("en1_spacing", 1, en_at[1][1] - en_at[1][0], 200);

        // Reset at cycle 60 of a frame.
        rst = 1'b1; run = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; run = 1'b1;
        r  = cyc;
        t0 = r + SP0 - 1;
        while (cyc < t0 + 60) @(negedge clk);
        nb  = en_n[0];
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cs_n", 0, cs_w[0], 1);
        check("midrst_sclk", 0, sclk_w[0], 1);
        check("midrst_u",    0, u_w[0], 0);
        rst = 1'b0;
        t1 = cyc + SP0 - 1;
        while (cyc < t0 + 200) @(negedge clk);
        check("midrst_no_en", 0, en_n[0], nb);

        // Run dropped at cycle 50 of a frame.
        while (cyc < t1 + 50) @(negedge clk);
        nb  = en_n[0];
        run = 1'b0;
        while (cyc < t1 + 140) @(negedge clk);
        check("rundrop_en_count", 0, en_n[0], nb + 1);
        check("rundrop_en_cycle", 0, en_at[0][nb], t1 + 133);
        cs_low = 0;
        repeat (3000) begin
            @(negedge clk);
            if (cs_w[0] !== 1'b1) cs_low++;
        end
        check("rundrop_no_cs", 0, cs_low, 0);

        // Randomised Run / Reset activity.
        for (int k = 0; k < 12; k++) begin
            run  = ($urandom_range(0, 3) != 0);
            hold = $urandom_range(50, 3000);
            if ($urandom_range(0, 5) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end
            repeat (hold) @(negedge clk);
        end

        run = 1'b0;
        repeat (200) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
